// File: rtl/reg_file_sb.sv
// Register file with two bypassed read ports, one write port, a debug port,
// optional hardwired-zero register, pending-write scoreboard and a power-up init sweep.
module reg_file_sb #(
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 32,
  parameter int                ADDR_W     = 5,
  parameter int                ZERO_REG   = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              init_done,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic [DATA_W-1:0] debug_data
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] idx_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  pending_r;
  logic [DEPTH-1:0]  pending_nxt_s;
  logic              run_s;
  logic              init_we_s;
  logic              last_idx_s;
  logic              wr_ok_s;
  logic              issue_ok_s;
  logic [DATA_W-1:0] rd_nxt_1_s;
  logic [DATA_W-1:0] rd_nxt_2_s;
  logic [DATA_W-1:0] dbg_nxt_s;
  logic              busy_nxt_1_s;
  logic              busy_nxt_2_s;
  logic [DATA_W-1:0] rd_data_1_r;
  logic [DATA_W-1:0] rd_data_2_r;
  logic [DATA_W-1:0] debug_data_r;
  logic              busy_1_r;
  logic              busy_2_r;
  logic              init_done_r;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  function automatic logic is_valid(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  // Mux-style lookup; out-of-range addresses match no entry and yield zero.
  function automatic logic [DATA_W-1:0] mem_lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) v = mem_r[i];
    end
    return v;
  endfunction

  function automatic logic pend_lookup(input logic [DEPTH-1:0] p, input logic [ADDR_W-1:0] a);
    logic v;
    v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a == ADDR_W'(i)) v = p[i];
    end
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] read_next(input logic [ADDR_W-1:0] a, input logic we,
                                                  input logic [ADDR_W-1:0] wa,
                                                  input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] v;
    if (is_zero(a) || !is_valid(a)) v = {DATA_W{1'b0}};
    else if (we && (wa == a))       v = wd;
    else                            v = mem_lookup(a);
    return v;
  endfunction

  assign last_idx_s = (idx_r == ADDR_W'(DEPTH - 1));

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= ST_INIT;
    else          state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (last_idx_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_INIT;
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // FSM output decode
  always_comb begin
    run_s     = 1'b0;
    init_we_s = 1'b0;
    case (state_r)
      ST_INIT: init_we_s = 1'b1;
      ST_RUN:  run_s     = 1'b1;
      default: init_we_s = 1'b0;
    endcase
  end

  // Sweep index walks 0..DEPTH-1 while initialising
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                     idx_r <= {ADDR_W{1'b0}};
    else if (init_we_s && !last_idx_s) idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    else                              idx_r <= idx_r;
  end

  assign wr_ok_s    = run_s && wr_en && !is_zero(wr_addr);
  assign issue_ok_s = run_s && issue_en && !is_zero(issue_addr);

  // Scoreboard next state: set beats clear on the same entry
  always_comb begin
    pending_nxt_s = pending_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_ok_s && (issue_addr == ADDR_W'(i)))  pending_nxt_s[i] = 1'b1;
      else if (wr_ok_s && (wr_addr == ADDR_W'(i)))   pending_nxt_s[i] = 1'b0;
      else                                           pending_nxt_s[i] = pending_r[i];
    end
  end

  // Next values for the registered read, busy and debug outputs
  always_comb begin
    rd_nxt_1_s   = read_next(rd_addr_1, wr_ok_s, wr_addr, wr_data);
    rd_nxt_2_s   = read_next(rd_addr_2, wr_ok_s, wr_addr, wr_data);
    busy_nxt_1_s = is_valid(rd_addr_1) ? pend_lookup(pending_nxt_s, rd_addr_1) : 1'b0;
    busy_nxt_2_s = is_valid(rd_addr_2) ? pend_lookup(pending_nxt_s, rd_addr_2) : 1'b0;
    if (is_zero(debug_addr)) dbg_nxt_s = {DATA_W{1'b0}};
    else                     dbg_nxt_s = mem_lookup(debug_addr);
  end

  // Storage array: init sweep or functional write, deliberately not reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (init_we_s && (idx_r == ADDR_W'(i)))   mem_r[i] <= INIT_VALUE;
      else if (wr_ok_s && (wr_addr == ADDR_W'(i))) mem_r[i] <= wr_data;
    end
  end

  // Scoreboard flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pending_r <= {DEPTH{1'b0}};
    else          pending_r <= pending_nxt_s;
  end

  // Registered outputs, forced to zero while initialising
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_1_r  <= {DATA_W{1'b0}};
      rd_data_2_r  <= {DATA_W{1'b0}};
      debug_data_r <= {DATA_W{1'b0}};
      busy_1_r     <= 1'b0;
      busy_2_r     <= 1'b0;
      init_done_r  <= 1'b0;
    end else begin
      init_done_r <= (state_nxt_s == ST_RUN);
      if (run_s) begin
        rd_data_1_r  <= rd_nxt_1_s;
        rd_data_2_r  <= rd_nxt_2_s;
        debug_data_r <= dbg_nxt_s;
        busy_1_r     <= busy_nxt_1_s;
        busy_2_r     <= busy_nxt_2_s;
      end else begin
        rd_data_1_r  <= {DATA_W{1'b0}};
        rd_data_2_r  <= {DATA_W{1'b0}};
        debug_data_r <= {DATA_W{1'b0}};
        busy_1_r     <= 1'b0;
        busy_2_r     <= 1'b0;
      end
    end
  end

  assign rd_data_1  = rd_data_1_r;
  assign rd_data_2  = rd_data_2_r;
  assign debug_data = debug_data_r;
  assign busy_1     = busy_1_r;
  assign busy_2     = busy_2_r;
  assign init_done  = init_done_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a DEPTH=32 instance (INIT 0xA5) and a DEPTH=24 instance.
module tb_reg_file_sb;

  logic        clock;
  logic        reset_n;
  int          total;
  int          bad;

  logic [4:0]  rd_addr_1, rd_addr_2, wr_addr, issue_addr, debug_addr;
  logic [31:0] wr_data;
  logic        wr_en, issue_en;
  logic [31:0] rd_data_1, rd_data_2, debug_data;
  logic        busy_1, busy_2, init_done;

  logic [4:0]  b_rd_addr_1, b_rd_addr_2, b_wr_addr, b_issue_addr, b_debug_addr;
  logic [31:0] b_wr_data;
  logic        b_wr_en, b_issue_en;
  logic [31:0] b_rd_data_1, b_rd_data_2, b_debug_data;
  logic        b_busy_1, b_busy_2, b_init_done;

  reg_file_sb #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .INIT_VALUE(32'h0000_00A5)) u_a (
    .clock(clock), .reset_n(reset_n),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .init_done(init_done), .debug_addr(debug_addr), .debug_data(debug_data)
  );

  reg_file_sb #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1), .INIT_VALUE(32'h0000_005A)) u_b (
    .clock(clock), .reset_n(reset_n),
    .rd_addr_1(b_rd_addr_1), .rd_addr_2(b_rd_addr_2),
    .rd_data_1(b_rd_data_1), .rd_data_2(b_rd_data_2),
    .busy_1(b_busy_1), .busy_2(b_busy_2),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr),
    .init_done(b_init_done), .debug_addr(b_debug_addr), .debug_data(b_debug_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    total++;
    if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0 || debug_data !== 32'h0 ||
        busy_1 !== 1'b0 || busy_2 !== 1'b0 || init_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rd1=%h rd2=%h dbg=%h busy=%b%b done=%b want all 0",
               rd_data_1, rd_data_2, debug_data, busy_1, busy_2, init_done);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_init_sweep();
    logic early_a, early_b;
    early_a = 1'b0;
    early_b = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e < 32 && init_done !== 1'b0) early_a = 1'b1;
      if (e < 24 && b_init_done !== 1'b0) early_b = 1'b1;
      if (e == 24) begin
        total++;
        if (b_init_done !== 1'b1 || early_b) begin
          bad++;
          $display("FAIL init_b_edge24: done=%b early=%b want done=1 early=0", b_init_done, early_b);
        end
      end
    end
    total++;
    if (init_done !== 1'b1 || early_a) begin
      bad++;
      $display("FAIL init_a_edge32: done=%b early=%b want done=1 early=0", init_done, early_a);
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp1, exp2;
      rd_addr_1  = 5'(i);
      rd_addr_2  = 5'(31 - i);
      debug_addr = 5'(i);
      tick();
      exp1 = (i == 0) ? 32'h0 : 32'h0000_00A5;
      exp2 = (i == 31) ? 32'h0 : 32'h0000_00A5;
      total++;
      if (rd_data_1 !== exp1 || rd_data_2 !== exp2 || debug_data !== exp1) begin
        bad++;
        $display("FAIL init_read[%0d]: rd1=%h rd2=%h dbg=%h want %h %h %h",
                 i, rd_data_1, rd_data_2, debug_data, exp1, exp2, exp1);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF_FFE2;
    tick();
    wr_addr = 5'd2; wr_data = 32'h0000_0038;
    tick();
    wr_en = 1'b0; rd_addr_1 = 5'd1; rd_addr_2 = 5'd2;
    tick();
    total++;
    if (rd_data_1 !== 32'hFFFF_FFE2 || rd_data_2 !== 32'h0000_0038) begin
      bad++;
      $display("FAIL write_read: rd1=%h rd2=%h want ffffffe2 00000038", rd_data_1, rd_data_2);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
    rd_addr_1 = 5'd0;
    tick();
    total++;
    if (rd_data_1 !== 32'h0) begin
      bad++;
      $display("FAIL r0_bypass: rd1=%h want 0", rd_data_1);
    end
    wr_en = 1'b0; debug_addr = 5'd0;
    tick();
    total++;
    if (rd_data_1 !== 32'h0 || debug_data !== 32'h0) begin
      bad++;
      $display("FAIL r0_write: rd1=%h dbg=%h want 0 0", rd_data_1, debug_data);
    end
  endtask

  task automatic test_bypass();
    rd_addr_1 = 5'd7; debug_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_DEAD;
    tick();
    total++;
    if (rd_data_1 !== 32'h0000_DEAD || debug_data !== 32'h0000_00A5) begin
      bad++;
      $display("FAIL bypass_edge: rd1=%h dbg=%h want 0000dead 000000a5", rd_data_1, debug_data);
    end
    wr_en = 1'b0;
    tick();
    total++;
    if (rd_data_1 !== 32'h0000_DEAD || debug_data !== 32'h0000_DEAD) begin
      bad++;
      $display("FAIL bypass_next: rd1=%h dbg=%h want 0000dead 0000dead", rd_data_1, debug_data);
    end
  endtask

  task automatic test_scoreboard();
    rd_addr_1 = 5'd5; rd_addr_2 = 5'd5;
    issue_en = 1'b1; issue_addr = 5'd5;
    tick();
    total++;
    if (busy_1 !== 1'b1 || busy_2 !== 1'b1 || rd_data_1 !== 32'h0000_00A5) begin
      bad++;
      $display("FAIL sb_issue: busy=%b%b rd1=%h want 11 000000a5", busy_1, busy_2, rd_data_1);
    end
    issue_en = 1'b0;
    tick();
    total++;
    if (busy_1 !== 1'b1) begin
      bad++;
      $display("FAIL sb_hold: busy1=%b want 1", busy_1);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0055;
    tick();
    total++;
    if (busy_1 !== 1'b0 || rd_data_1 !== 32'h0000_0055) begin
      bad++;
      $display("FAIL sb_clear: busy1=%b rd1=%h want 0 00000055", busy_1, rd_data_1);
    end
    issue_en = 1'b1; issue_addr = 5'd5; wr_data = 32'h0000_0066;
    tick();
    total++;
    if (busy_1 !== 1'b1 || rd_data_1 !== 32'h0000_0066) begin
      bad++;
      $display("FAIL sb_set_wins: busy1=%b rd1=%h want 1 00000066", busy_1, rd_data_1);
    end
    issue_en = 1'b0; wr_data = 32'h0000_0077;
    tick();
    wr_en = 1'b0;
    issue_en = 1'b1; issue_addr = 5'd0; rd_addr_2 = 5'd0;
    tick();
    issue_en = 1'b0;
    total++;
    if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin
      bad++;
      $display("FAIL sb_r0: busy=%b%b want 00", busy_1, busy_2);
    end
  endtask

  task automatic test_invalid();
    b_wr_en = 1'b1; b_wr_addr = 5'd30; b_wr_data = 32'h0000_0077;
    b_issue_en = 1'b1; b_issue_addr = 5'd30;
    b_rd_addr_1 = 5'd30;
    tick();
    total++;
    if (b_rd_data_1 !== 32'h0 || b_busy_1 !== 1'b0) begin
      bad++;
      $display("FAIL inv_read: rd1=%h busy1=%b want 0 0", b_rd_data_1, b_busy_1);
    end
    b_wr_en = 1'b0; b_issue_en = 1'b0;
    b_rd_addr_1 = 5'd14; b_rd_addr_2 = 5'd6; b_debug_addr = 5'd22;
    tick();
    total++;
    if (b_rd_data_1 !== 32'h0000_005A || b_rd_data_2 !== 32'h0000_005A ||
        b_debug_data !== 32'h0000_005A || b_busy_1 !== 1'b0 || b_busy_2 !== 1'b0) begin
      bad++;
      $display("FAIL inv_no_alias: rd1=%h rd2=%h dbg=%h busy=%b%b want 5a 5a 5a 00",
               b_rd_data_1, b_rd_data_2, b_debug_data, b_busy_1, b_busy_2);
    end
    b_wr_en = 1'b1; b_wr_addr = 5'd23; b_wr_data = 32'h0000_0099;
    tick();
    b_wr_en = 1'b0; b_rd_addr_1 = 5'd23;
    tick();
    total++;
    if (b_rd_data_1 !== 32'h0000_0099) begin
      bad++;
      $display("FAIL last_valid: rd1=%h want 00000099", b_rd_data_1);
    end
  endtask

  task automatic test_mid_reset();
    int rise;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_1111;
    tick();
    wr_en = 1'b0; rd_addr_1 = 5'd3;
    tick();
    total++;
    if (rd_data_1 !== 32'h0000_1111) begin
      bad++;
      $display("FAIL pre_reset_read: rd1=%h want 00001111", rd_data_1);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (init_done !== 1'b0 || rd_data_1 !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: done=%b rd1=%h want 0 0", init_done, rd_data_1);
    end
    tick();
    reset_n = 1'b1;
    for (int e = 0; e < 10; e++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_3333;
    issue_en = 1'b1; issue_addr = 5'd3;
    rise = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 20) begin
        total++;
        if (rd_data_1 !== 32'h0 || busy_1 !== 1'b0) begin
          bad++;
          $display("FAIL init_hold: rd1=%h busy1=%b want 0 0", rd_data_1, busy_1);
        end
      end
      if (init_done === 1'b1) begin
        rise = e;
        break;
      end
    end
    wr_en = 1'b0; issue_en = 1'b0;
    total++;
    if (rise != 32) begin
      bad++;
      $display("FAIL mid_reset_rise: edge=%0d want 32", rise);
    end
    tick();
    total++;
    if (rd_data_1 !== 32'h0000_00A5 || busy_1 !== 1'b0) begin
      bad++;
      $display("FAIL init_write_ignored: rd1=%h busy1=%b want 000000a5 0", rd_data_1, busy_1);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0;
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd0; wr_addr = 5'd0; issue_addr = 5'd0; debug_addr = 5'd0;
    wr_data = 32'h0; wr_en = 1'b0; issue_en = 1'b0;
    b_rd_addr_1 = 5'd0; b_rd_addr_2 = 5'd0; b_wr_addr = 5'd0; b_issue_addr = 5'd0;
    b_debug_addr = 5'd0; b_wr_data = 32'h0; b_wr_en = 1'b0; b_issue_en = 1'b0;
    test_reset();
    test_init_sweep();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_invalid();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the MIPS datapath: two synchronous read ports, one write port, a debug read port, write-to-read bypass, a hardwired-zero register, and a per-register pending-write scoreboard for pipeline hazard detection. Register storage is not flop-reset. After reset, an internal init sequencer sweeps every entry to `INIT_VALUE` and then raises `init_done`. The block sits between decode (reads and issue marking) and writeback (writes and pending clear).

## Interface
- `DATA_W`, 32, register width in bits
- `DEPTH`, 32, number of registers (2..256, need not be a power of two)
- `ADDR_W`, 5, address width; must satisfy 2^ADDR_W >= DEPTH
- `ZERO_REG`, 1, when 1, register 0 always reads 0 and ignores writes and issues
- `INIT_VALUE`, 0, value written to every entry by the init sweep
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `rd_addr_1`, `rd_addr_2`  in  ADDR_W  read addresses
- `rd_data_1`, `rd_data_2`  out  DATA_W  registered read data
- `busy_1`, `busy_2`  out  1  registered pending flag for the matching read address
- `wr_en`  in  1  write strobe; also clears the pending bit
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `issue_en`  in  1  sets the pending bit at `issue_addr` (a producer is in flight)
- `issue_addr`  in  ADDR_W  destination of the issued instruction
- `init_done`  out  1  high once the init sweep has completed
- `debug_addr`  in  ADDR_W  debug read address
- `debug_data`  out  DATA_W  registered debug read data, no bypass

## Operation
- **FSM states.**
  - INIT is entered asynchronously on `reset_n`=0.
  - After reset release, one entry per cycle is written with `INIT_VALUE`, at indices 0..DEPTH-1.
  - After the last index, the FSM moves to RUN and `init_done` goes to 1.
  - RUN is held until the next reset.
- **During INIT.**
  - `wr_en` and `issue_en` are ignored.
  - `rd_data_x`, `busy_x` and `debug_data` are held at 0.
- **Invalid addresses.** A write or issue to an address >= DEPTH is ignored. A read from an address >= DEPTH returns 0 with busy 0.
- **Read path (RUN).** At each edge, `rd_data_x` is loaded by the first matching rule:
  - 0 if `ZERO_REG` and `rd_addr_x`==0;
  - otherwise `wr_data` if `wr_en` and `wr_addr`==`rd_addr_x` (write-through bypass);
  - otherwise `mem[rd_addr_x]`.
- **Write (RUN).** `mem[wr_addr]` <= `wr_data` on `wr_en`. A write to register 0 is dropped when `ZERO_REG`=1.
- **Scoreboard.**
  - `pending[DEPTH]` is a set of flops, all cleared by reset.
  - `wr_en` clears `pending[wr_addr]`.
  - `issue_en` sets `pending[issue_addr]`.
  - If both target the same address on the same edge, set wins.
  - When `ZERO_REG`=1, `pending[0]` stays 0.
- **Busy output.** `busy_x` is loaded with the next-state value of `pending[rd_addr_x]`, i.e. the value after this edge's clear and set. It is therefore coherent with the bypassed `rd_data_x`.
- **Debug port.** `debug_data` <= `mem[debug_addr]` (0 for register 0 when `ZERO_REG`). It reflects the array before the current edge's write.

## Timing
- **Reset values.** `rd_data_1`/`rd_data_2`/`debug_data` = 0, `busy_1`/`busy_2` = 0, `init_done` = 0, all pending bits = 0. The sweep index resets to 0.
- **Init latency.** `init_done` rises on the DEPTH-th rising edge after `reset_n` deasserts, i.e. DEPTH cycles of INIT.
- **Read latency.** 1 cycle: the address is presented before edge N; data and busy are valid after edge N.
- **Write visibility.**
  - A write at edge N is visible to a read presented for edge N via the bypass.
  - It is visible to the debug port from edge N+1.
- **Scoreboard latency.** An issue at edge N makes `busy_x` = 1 for a read presented at edge N.
- **Mid-sweep reset.** Reset asserted during INIT restarts the sweep from index 0, and `init_done` stays 0.
- **Reset in RUN.** Reset asserted in RUN re-enters INIT immediately and asynchronously.

## Test plan
- **Init sweep.** DEPTH=32, INIT_VALUE=0xA5: release reset -> `init_done`=0 for 31 edges and 1 at edge 32. Afterwards, reading all 32 addresses returns 0xA5, except register 0 which returns 0.
- **Write then read.** Write 0xFFFFFFE2 to r1 and 0x38 to r2 in consecutive cycles, then read r1/r2 -> `rd_data_1`=0xFFFFFFE2, `rd_data_2`=0x38 one cycle later. A write of 0x1234 to r0 reads back 0.
- **Bypass.** Write 0xDEAD to r7 with `rd_addr_1`=7 on the same edge -> `rd_data_1`=0xDEAD. `debug_data` for r7 is the old value on that edge and 0xDEAD on the next.
- **Scoreboard.** Issue r5 -> `busy_1`(r5)=1. Write r5 with no issue -> busy=0 and data bypassed. Issue and write r5 on the same edge -> busy stays 1.
- **Mid-sweep reset.** Assert `reset_n`=0 at sweep index 10 and release -> `init_done` first rises 32 cycles after the second release. Writes attempted during INIT are ignored, and the target reads INIT_VALUE.
- **Invalid addresses.** With DEPTH=24, ADDR_W=5: a write to address 30 is ignored, and a read of address 30 returns 0 with busy 0.
